// File: rtl/div_reservation_station_if.sv
// Divide reservation station bus definitions.
//   div_rs_pkg   : decoded divide control payload.
//   div_rs_if    : dispatch port, CDB snoop port and issue port of the station.
//     master : upstream/environment side (drives dispatch, CDB, output_ready)
//     slave  : reservation station side (drives in_ready, alloc_rs_id, issue outputs)
package div_rs_pkg;
   typedef struct packed {
      logic is_signed;
      logic is_rem;
      logic is_word;
   } div_decode_t;
endpackage

interface div_rs_if #(
   parameter int unsigned RS_ID_WIDTH = 5
);
   // dispatch
   logic                          in_valid;
   logic                          in_ready;
   logic [RS_ID_WIDTH-1:0]        alloc_rs_id;
   logic [31:0]                   in_op1;
   logic [31:0]                   in_op2;
   logic                          in_op1_valid;
   logic                          in_op2_valid;
   logic [RS_ID_WIDTH-1:0]        in_op1_tag;
   logic [RS_ID_WIDTH-1:0]        in_op2_tag;
   div_rs_pkg::div_decode_t       in_control;
   logic [4:0]                    in_result_reg_addr;
   // common data bus
   logic                          cdb_valid;
   logic [RS_ID_WIDTH-1:0]        cdb_rs_id;
   logic [31:0]                   cdb_result;
   // issue to divider
   logic                          output_valid;
   logic                          output_ready;
   logic [RS_ID_WIDTH-1:0]        rs_id_out;
   logic [4:0]                    result_reg_addr_out;
   logic [31:0]                   op1;
   logic [31:0]                   op2;
   div_rs_pkg::div_decode_t       control;

   modport master (
      output in_valid, in_op1, in_op2, in_op1_valid, in_op2_valid, in_op1_tag, in_op2_tag,
             in_control, in_result_reg_addr, cdb_valid, cdb_rs_id, cdb_result, output_ready,
      input  in_ready, alloc_rs_id, output_valid, rs_id_out, result_reg_addr_out, op1, op2,
             control
   );

   modport slave (
      input  in_valid, in_op1, in_op2, in_op1_valid, in_op2_valid, in_op1_tag, in_op2_tag,
             in_control, in_result_reg_addr, cdb_valid, cdb_rs_id, cdb_result, output_ready,
      output in_ready, alloc_rs_id, output_valid, rs_id_out, result_reg_addr_out, op1, op2,
             control
   );
endinterface

// File: rtl/div_reservation_station.sv
// Reservation station in front of the divide unit. Holds DEPTH entries that wait
// for operands via CDB snooping, issues READY entries lowest-index first through a
// registered valid/ready port, and frees an entry when its own tag is broadcast.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_rs_if slave (dispatch, CDB snoop, issue port)
module div_reservation_station
   import div_rs_pkg::*;
#(
   parameter int unsigned RS_ID_WIDTH = 5,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned RS_OFFSET   = 0
) (
   input  logic     clk,
   input  logic     rst,
   div_rs_if.slave  bus
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {E_FREE, E_WAITING, E_READY, E_ISSUED} ent_state_e;

   typedef struct packed {
      logic [31:0]            op1;
      logic [31:0]            op2;
      logic [RS_ID_WIDTH-1:0] tag1;
      logic [RS_ID_WIDTH-1:0] tag2;
      logic                   pend1;
      logic                   pend2;
      div_decode_t            ctrl;
      logic [4:0]             rd;
   } entry_t;

   ent_state_e             st_q  [DEPTH];
   ent_state_e             st_d  [DEPTH];
   entry_t                 ent_q [DEPTH];
   entry_t                 ent_d [DEPTH];

   logic                   ov_q, ov_d;
   logic [RS_ID_WIDTH-1:0] oid_q, oid_d;
   logic [4:0]             ord_q, ord_d;
   logic [31:0]            oop1_q, oop1_d;
   logic [31:0]            oop2_q, oop2_d;
   div_decode_t            octrl_q, octrl_d;

   logic                   free_found_c, rdy_found_c;
   logic [IDX_W-1:0]       free_idx_c, rdy_idx_c;
   logic                   dispatch_c, load_en_c;
   entry_t                 new_ent_c;

   // Lowest-index FREE and READY entries (priority scan from the top down)
   always_comb begin
      free_found_c = 1'b0;
      free_idx_c   = '0;
      rdy_found_c  = 1'b0;
      rdy_idx_c    = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (st_q[k] == E_FREE) begin
            free_found_c = 1'b1;
            free_idx_c   = IDX_W'(k);
         end
         if (st_q[k] == E_READY) begin
            rdy_found_c = 1'b1;
            rdy_idx_c   = IDX_W'(k);
         end
      end
   end

   assign dispatch_c = bus.in_valid & free_found_c;
   assign load_en_c  = ~ov_q | bus.output_ready;

   // Incoming entry; a same-cycle CDB broadcast of a missing tag is forwarded
   always_comb begin
      new_ent_c       = '0;
      new_ent_c.ctrl  = bus.in_control;
      new_ent_c.rd    = bus.in_result_reg_addr;
      new_ent_c.tag1  = bus.in_op1_tag;
      new_ent_c.tag2  = bus.in_op2_tag;
      new_ent_c.op1   = bus.in_op1;
      new_ent_c.op2   = bus.in_op2;
      new_ent_c.pend1 = 1'b0;
      new_ent_c.pend2 = 1'b0;
      if (!bus.in_op1_valid) begin
         if (bus.cdb_valid && bus.cdb_rs_id == bus.in_op1_tag) new_ent_c.op1 = bus.cdb_result;
         else new_ent_c.pend1 = 1'b1;
      end
      if (!bus.in_op2_valid) begin
         if (bus.cdb_valid && bus.cdb_rs_id == bus.in_op2_tag) new_ent_c.op2 = bus.cdb_result;
         else new_ent_c.pend2 = 1'b1;
      end
   end

   // Entry state machines and issue register next state
   always_comb begin
      st_d    = st_q;
      ent_d   = ent_q;
      ov_d    = ov_q;
      oid_d   = oid_q;
      ord_d   = ord_q;
      oop1_d  = oop1_q;
      oop2_d  = oop2_q;
      octrl_d = octrl_q;

      for (int k = 0; k < int'(DEPTH); k++) begin
         case (st_q[k])
            E_FREE: begin
               if (dispatch_c && free_idx_c == IDX_W'(k)) begin
                  ent_d[k] = new_ent_c;
                  st_d[k]  = (new_ent_c.pend1 || new_ent_c.pend2) ? E_WAITING : E_READY;
               end
            end
            E_WAITING: begin
               if (bus.cdb_valid && ent_q[k].pend1 && ent_q[k].tag1 == bus.cdb_rs_id) begin
                  ent_d[k].op1   = bus.cdb_result;
                  ent_d[k].pend1 = 1'b0;
               end
               if (bus.cdb_valid && ent_q[k].pend2 && ent_q[k].tag2 == bus.cdb_rs_id) begin
                  ent_d[k].op2   = bus.cdb_result;
                  ent_d[k].pend2 = 1'b0;
               end
               if (!ent_d[k].pend1 && !ent_d[k].pend2) st_d[k] = E_READY;
            end
            E_READY: begin
               if (load_en_c && rdy_found_c && rdy_idx_c == IDX_W'(k)) st_d[k] = E_ISSUED;
            end
            E_ISSUED: begin
               // Tag compare against this entry's own global ID releases it
               if (bus.cdb_valid &&
                   bus.cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + unsigned'(k))) st_d[k] = E_FREE;
            end
            default: st_d[k] = E_FREE;
         endcase
      end

      if (load_en_c) begin
         if (rdy_found_c) begin
            ov_d    = 1'b1;
            oid_d   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(rdy_idx_c);
            ord_d   = ent_q[rdy_idx_c].rd;
            oop1_d  = ent_q[rdy_idx_c].op1;
            oop2_d  = ent_q[rdy_idx_c].op2;
            octrl_d = ent_q[rdy_idx_c].ctrl;
         end else begin
            ov_d = 1'b0;
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            st_q[k]  <= E_FREE;
            ent_q[k] <= '0;
         end
         ov_q    <= 1'b0;
         oid_q   <= '0;
         ord_q   <= '0;
         oop1_q  <= '0;
         oop2_q  <= '0;
         octrl_q <= '0;
      end else begin
         st_q    <= st_d;
         ent_q   <= ent_d;
         ov_q    <= ov_d;
         oid_q   <= oid_d;
         ord_q   <= ord_d;
         oop1_q  <= oop1_d;
         oop2_q  <= oop2_d;
         octrl_q <= octrl_d;
      end
   end

   assign bus.in_ready            = free_found_c;
   assign bus.alloc_rs_id         = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx_c);
   assign bus.output_valid        = ov_q;
   assign bus.rs_id_out           = oid_q;
   assign bus.result_reg_addr_out = ord_q;
   assign bus.op1                 = oop1_q;
   assign bus.op2                 = oop2_q;
   assign bus.control             = octrl_q;

endmodule

// File: tb/tb_div_reservation_station.sv
// Scoreboard bench for div_reservation_station: stimulus pushes expected issue
// records, a negedge monitor pops and compares on every accepted issue.
module tb_div_reservation_station;
   import div_rs_pkg::*;

   logic clk;
   logic rst;

   div_rs_if #(.RS_ID_WIDTH(5)) bus ();

   div_reservation_station #(.RS_ID_WIDTH(5), .DEPTH(4), .RS_OFFSET(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4:0]  id;
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
      div_decode_t ctrl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam div_decode_t C1 = '{is_signed: 1'b1, is_rem: 1'b0, is_word: 1'b0};
   localparam div_decode_t C2 = '{is_signed: 1'b0, is_rem: 1'b1, is_word: 1'b0};
   localparam div_decode_t C3 = '{is_signed: 1'b1, is_rem: 1'b1, is_word: 1'b1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, expv);
      end
   endtask

   task automatic push(input logic [4:0] id, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input div_decode_t c);
      exp_t e;
      e.id = id; e.rd = rd; e.op1 = a; e.op2 = b; e.ctrl = c;
      sb.push_back(e);
   endtask

   task automatic dispatch(input logic [31:0] a, input logic av, input logic [4:0] at,
                           input logic [31:0] b, input logic bv, input logic [4:0] bt,
                           input logic [4:0] rd, input div_decode_t c);
      bus.in_valid           = 1'b1;
      bus.in_op1             = a;
      bus.in_op1_valid       = av;
      bus.in_op1_tag         = at;
      bus.in_op2             = b;
      bus.in_op2_valid       = bv;
      bus.in_op2_tag         = bt;
      bus.in_result_reg_addr = rd;
      bus.in_control         = c;
   endtask

   task automatic cdb(input logic v, input logic [4:0] id, input logic [31:0] res);
      bus.cdb_valid  = v;
      bus.cdb_rs_id  = id;
      bus.cdb_result = res;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      cdb(1'b0, 5'd0, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   // Monitor: every accepted issue must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && bus.output_valid && bus.output_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected got id=%0d op1=%0h op2=%0h exp none",
                     bus.rs_id_out, bus.op1, bus.op2);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.rs_id_out !== e.id || bus.result_reg_addr_out !== e.rd ||
                bus.op1 !== e.op1 || bus.op2 !== e.op2 || bus.control !== e.ctrl) begin
               errors++;
               $display("FAIL issue got id=%0d rd=%0d op1=%0h op2=%0h ctrl=%0h exp id=%0d rd=%0d op1=%0h op2=%0h ctrl=%0h",
                        bus.rs_id_out, bus.result_reg_addr_out, bus.op1, bus.op2, bus.control,
                        e.id, e.rd, e.op1, e.op2, e.ctrl);
            end
         end
      end
   end

   initial begin
      rst                    = 1'b1;
      bus.in_valid           = 1'b0;
      bus.in_op1             = '0;
      bus.in_op2             = '0;
      bus.in_op1_valid       = 1'b0;
      bus.in_op2_valid       = 1'b0;
      bus.in_op1_tag         = '0;
      bus.in_op2_tag         = '0;
      bus.in_control         = '0;
      bus.in_result_reg_addr = '0;
      bus.output_ready       = 1'b1;
      cdb(1'b0, 5'd0, 32'd0);

      // Reset values and all-valid dispatch latency
      do_reset();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_alloc", 32'(bus.alloc_rs_id), 32'd0);
      chk("rst_ov", 32'(bus.output_valid), 32'd0);
      chk("rst_rs_id_out", 32'(bus.rs_id_out), 32'd0);
      chk("rst_op1", bus.op1, 32'd0);
      chk("rst_op2", bus.op2, 32'd0);
      chk("rst_ctrl", 32'(bus.control), 32'd0);
      dispatch(32'd100, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 5'd3, C1);
      chk("t1_alloc", 32'(bus.alloc_rs_id), 32'd0);
      push(5'd0, 5'd3, 32'd100, 32'd7, C1);
      tick();
      bus.in_valid = 1'b0;
      chk("t1_ov_t1", 32'(bus.output_valid), 32'd0);
      tick();
      chk("t1_ov_t2", 32'(bus.output_valid), 32'd1);
      chk("t1_rs_id", 32'(bus.rs_id_out), 32'd0);
      chk("t1_rd", 32'(bus.result_reg_addr_out), 32'd3);
      tick();
      tick();
      chk("t1_drained", 32'(sb.size()), 32'd0);

      // Pending op2 woken by a later broadcast of tag 9
      do_reset();
      dispatch(32'd50, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9, 5'd4, C2);
      push(5'd0, 5'd4, 32'd50, 32'd5, C2);
      tick();
      bus.in_valid = 1'b0;
      chk("t2_ov_t1", 32'(bus.output_valid), 32'd0);
      tick();
      chk("t2_ov_t2", 32'(bus.output_valid), 32'd0);
      tick();
      chk("t2_ov_t3", 32'(bus.output_valid), 32'd0);
      cdb(1'b1, 5'd9, 32'd5);
      tick();
      cdb(1'b0, 5'd0, 32'd0);
      chk("t2_ov_ready", 32'(bus.output_valid), 32'd0);
      tick();
      chk("t2_ov_issue", 32'(bus.output_valid), 32'd1);
      chk("t2_op2", bus.op2, 32'd5);
      tick();
      tick();
      chk("t2_drained", 32'(sb.size()), 32'd0);

      // Same-cycle CDB forward at dispatch
      do_reset();
      dispatch(32'd0, 1'b0, 5'd12, 32'd3, 1'b1, 5'd0, 5'd7, C3);
      cdb(1'b1, 5'd12, 32'hFFFF_FFF0);
      push(5'd0, 5'd7, 32'hFFFF_FFF0, 32'd3, C3);
      tick();
      bus.in_valid = 1'b0;
      cdb(1'b0, 5'd0, 32'd0);
      chk("t3_ov_t1", 32'(bus.output_valid), 32'd0);
      tick();
      chk("t3_ov_t2", 32'(bus.output_valid), 32'd1);
      chk("t3_op1", bus.op1, 32'hFFFF_FFF0);
      tick();
      tick();
      chk("t3_drained", 32'(sb.size()), 32'd0);

      // Fill all entries with the divider stalled, hold, then free entry 0
      do_reset();
      bus.output_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t4_in_ready_fill", 32'(bus.in_ready), 32'd1);
         chk("t4_alloc_fill", 32'(bus.alloc_rs_id), 32'(i));
         dispatch(32'd1000 + 32'(i), 1'b1, 5'd0, 32'd10 + 32'(i), 1'b1, 5'd0, 5'(i), C1);
         push(5'(i), 5'(i), 32'd1000 + 32'(i), 32'd10 + 32'(i), C1);
         tick();
      end
      chk("t4_full", 32'(bus.in_ready), 32'd0);
      dispatch(32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 5'd31, C3);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_ov", 32'(bus.output_valid), 32'd1);
         chk("t4_hold_id", 32'(bus.rs_id_out), 32'd0);
         chk("t4_hold_op1", bus.op1, 32'd1000);
         chk("t4_hold_op2", bus.op2, 32'd10);
         tick();
      end
      cdb(1'b1, 5'd0, 32'd0);
      chk("t4_full_at_free", 32'(bus.in_ready), 32'd0);
      tick();
      cdb(1'b0, 5'd0, 32'd0);
      chk("t4_in_ready_back", 32'(bus.in_ready), 32'd1);
      chk("t4_alloc_back", 32'(bus.alloc_rs_id), 32'd0);
      bus.output_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("t4_drained", 32'(sb.size()), 32'd0);

      // Out-of-order issue: entries 1,2 ready before waiting entry 0
      do_reset();
      dispatch(32'd77, 1'b0, 5'd20, 32'd11, 1'b1, 5'd0, 5'd1, C1);
      chk("t5_alloc0", 32'(bus.alloc_rs_id), 32'd0);
      tick();
      dispatch(32'd200, 1'b1, 5'd0, 32'd20, 1'b1, 5'd0, 5'd2, C2);
      chk("t5_alloc1", 32'(bus.alloc_rs_id), 32'd1);
      push(5'd1, 5'd2, 32'd200, 32'd20, C2);
      tick();
      dispatch(32'd300, 1'b1, 5'd0, 32'd30, 1'b1, 5'd0, 5'd5, C3);
      chk("t5_alloc2", 32'(bus.alloc_rs_id), 32'd2);
      push(5'd2, 5'd5, 32'd300, 32'd30, C3);
      tick();
      bus.in_valid = 1'b0;
      chk("t5_first_id", 32'(bus.rs_id_out), 32'd1);
      tick();
      chk("t5_second_id", 32'(bus.rs_id_out), 32'd2);
      tick();
      chk("t5_idle_ov", 32'(bus.output_valid), 32'd0);
      cdb(1'b1, 5'd20, 32'd88);
      push(5'd0, 5'd1, 32'd88, 32'd11, C1);
      tick();
      cdb(1'b0, 5'd0, 32'd0);
      tick();
      chk("t5_third_ov", 32'(bus.output_valid), 32'd1);
      chk("t5_third_id", 32'(bus.rs_id_out), 32'd0);
      tick();
      tick();
      chk("t5_drained", 32'(sb.size()), 32'd0);

      // Reset mid-operation discards entries and the issue register
      do_reset();
      bus.output_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dispatch(32'd40 + 32'(i), 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 5'd9, C2);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      chk("t6_ov_before", 32'(bus.output_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ov_after", 32'(bus.output_valid), 32'd0);
      chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t6_alloc", 32'(bus.alloc_rs_id), 32'd0);
      chk("t6_rs_id_out", 32'(bus.rs_id_out), 32'd0);
      chk("t6_op1", bus.op1, 32'd0);
      bus.output_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_no_stale", 32'(bus.output_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
